// File: rtl/alu_share_ctrl.sv
// Two-port round-robin sequencer sharing one bit_8_alu, with a backpressured response channel.
// Optional build macro: ALU_SHARE_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round robin.

module bit_8_alu (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] ALU_Sel,
    input  logic       Cin,
    output logic [7:0] ALU_Out,
    output logic       Cout
);

    logic [8:0] res_s;

    // Opcode decode; bit 8 carries the add carry or the subtract borrow
    always_comb begin
        res_s = 9'd0;
        case (ALU_Sel)
            3'b000:  res_s = {1'b0, A & B};
            3'b001:  res_s = {1'b0, A | B};
            3'b010:  res_s = {1'b0, A ^ B};
            3'b011:  res_s = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
            3'b100:  res_s = {1'b0, A} - {1'b0, B};
            3'b101:  res_s = {1'b0, A};
            3'b110:  res_s = {1'b0, B};
            3'b111:  res_s = {1'b0, ~A};
            default: res_s = 9'd0;
        endcase
    end

    assign ALU_Out = res_s[7:0];
    assign Cout    = res_s[8];

endmodule

module alu_share_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic [2:0]   r0_sel,
    input  logic         r0_cin,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    input  logic [2:0]   r1_sel,
    input  logic         r1_cin,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_out,
    output logic         resp_cout,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_r;
    logic [W-1:0] op_a_r;
    logic [W-1:0] op_b_r;
    logic [2:0]   op_sel_r;
    logic         op_cin_r;
    logic         op_id_r;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic         last_r;
`endif

    logic         grant_valid_s;
    logic         grant_id_s;
    logic         accept_s;
    logic [W-1:0] alu_out_s;
    logic         alu_cout_s;

    // Arbitration: a lone requester always wins; contention resolved by policy
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_valid_s = 1'b1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
            grant_id_s    = 1'b0;
`else
            grant_id_s    = ~last_r;
`endif
        end else if (r0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (r1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    assign r0_ready = (state_r == IDLE) && grant_valid_s && !grant_id_s;
    assign r1_ready = (state_r == IDLE) && grant_valid_s &&  grant_id_s;
    assign accept_s = (state_r == IDLE) && grant_valid_s;

    // The ALU only ever sees the captured operands, never live requester inputs
    bit_8_alu u_alu (
        .A       (op_a_r),
        .B       (op_b_r),
        .ALU_Sel (op_sel_r),
        .Cin     (op_cin_r),
        .ALU_Out (alu_out_s),
        .Cout    (alu_cout_s)
    );

    // Sequencer: capture on accept, execute one cycle, hold response until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            op_a_r     <= {W{1'b0}};
            op_b_r     <= {W{1'b0}};
            op_sel_r   <= 3'd0;
            op_cin_r   <= 1'b0;
            op_id_r    <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_r     <= 1'b1;
`endif
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_out   <= {W{1'b0}};
            resp_cout  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_a_r   <= grant_id_s ? r1_a   : r0_a;
                        op_b_r   <= grant_id_s ? r1_b   : r0_b;
                        op_sel_r <= grant_id_s ? r1_sel : r0_sel;
                        op_cin_r <= grant_id_s ? r1_cin : r0_cin;
                        op_id_r  <= grant_id_s;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        last_r   <= grant_id_s;
`endif
                        busy     <= 1'b1;
                        state_r  <= EXEC;
                    end else begin
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                EXEC: begin
                    resp_out   <= alu_out_s;
                    resp_cout  <= alu_cout_s;
                    resp_id    <= op_id_r;
                    resp_valid <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r    <= RESP;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed ops push expected responses, a monitor pops and compares.

module tb_alu_share_ctrl;

    typedef struct packed {
        logic       id;
        logic [7:0] out;
        logic       cout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_valid, r1_valid;
    logic       r0_ready, r1_ready;
    logic [7:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0] r0_sel, r1_sel;
    logic       r0_cin, r1_cin;
    logic       resp_valid, resp_ready, resp_id, resp_cout, busy;
    logic [7:0] resp_out;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    alu_share_ctrl #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_sel(r0_sel), .r0_cin(r0_cin),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_sel(r1_sel), .r1_cin(r1_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_cout(resp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                check("resp_out", {24'd0, resp_out}, {24'd0, e.out});
                check("resp_cout", {31'd0, resp_cout}, {31'd0, e.cout});
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", q.size(), 32'd0);
    endtask

    task automatic push_exp(input logic id, input logic [7:0] eo, input logic ec);
        exp_t e;
        e.id = id; e.out = eo; e.cout = ec;
        q.push_back(e);
    endtask

    task automatic do_op(input logic port, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel, input logic cin,
                         input logic [7:0] eo, input logic ec, input bit chk_lat);
        bit got;
        got = 1'b0;
        if (port == 1'b0) begin
            r0_a = a; r0_b = b; r0_sel = sel; r0_cin = cin; r0_valid = 1'b1;
        end else begin
            r1_a = a; r1_b = b; r1_sel = sel; r1_cin = cin; r1_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 1'b0 && r0_ready) || (port == 1'b1 && r1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        check("accept", {31'd0, got}, 32'd1);
        if (got) push_exp(port, eo, ec);
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            check("lat1_valid", {31'd0, resp_valid}, 32'd0);
            check("lat1_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            check("lat2_valid", {31'd0, resp_valid}, 32'd1);
        end
        wait_drain();
        @(posedge clk); #1;
    endtask

    logic [7:0] sweep_exp [7];
    logic [2:0] sweep_sel [7];
    logic       grant_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sweep_sel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        sweep_exp = '{8'h41, 8'h4F, 8'h0E, 8'h0A, 8'h4D, 8'h43, 8'hB2};
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        grant_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        rst = 1'b1; resp_ready = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a = 8'd0; r0_b = 8'd0; r0_sel = 3'd0; r0_cin = 1'b0;
        r1_a = 8'd0; r1_b = 8'd0; r1_sel = 3'd0; r1_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_resp_out", {24'd0, resp_out}, 32'd0);
        check("rst_resp_id", {31'd0, resp_id}, 32'd0);
        check("rst_resp_cout", {31'd0, resp_cout}, 32'd0);
        check("rst_readys", {30'd0, r1_ready, r0_ready}, 32'd0);
        @(posedge clk); #1;

        // Single op with latency check
        do_op(1'b0, 8'h4D, 8'h43, 3'b011, 1'b0, 8'h90, 1'b0, 1'b1);

        // Opcode sweep on port 1
        for (int i = 0; i < 7; i++)
            do_op(1'b1, 8'h4D, 8'h43, sweep_sel[i], 1'b0, sweep_exp[i], 1'b0, 1'b0);

        // Carry cases
        do_op(1'b0, 8'hFF, 8'h01, 3'b011, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(1'b1, 8'hFF, 8'h01, 3'b011, 1'b1, 8'h01, 1'b1, 1'b0);

        // Contention: last grant went to port 1, so port 0 wins first
        r0_a = 8'h01; r0_b = 8'h02; r0_sel = 3'b011; r0_cin = 1'b0;
        r1_a = 8'h10; r1_b = 8'h20; r1_sel = 3'b011; r1_cin = 1'b0;
        for (int i = 0; i < 4; i++)
            push_exp(grant_exp[i], grant_exp[i] ? 8'h30 : 8'h03, 1'b0);
        r0_valid = 1'b1; r1_valid = 1'b1;
        begin
            int acc;
            acc = 0;
            for (int i = 0; i < 100 && acc < 4; i++) begin
                @(negedge clk);
                if (r0_ready || r1_ready) begin
                    check("cont_grant", {30'd0, r1_ready, r0_ready},
                          grant_exp[acc] ? 32'd2 : 32'd1);
                    acc++;
                end
            end
            check("cont_accepts", acc, 32'd4);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;

        // Backpressure: r0 response held while r1 waits
        resp_ready = 1'b0;
        r0_a = 8'h0F; r0_b = 8'hF0; r0_sel = 3'b001; r0_cin = 1'b0; r0_valid = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0_ready) begin got = 1'b1; break; end
            end
            check("bp_accept", {31'd0, got}, 32'd1);
        end
        push_exp(1'b0, 8'hFF, 1'b0);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_a = 8'h33; r1_b = 8'h11; r1_sel = 3'b100; r1_cin = 1'b0; r1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_out", {24'd0, resp_out}, 32'hFF);
            check("bp_id", {31'd0, resp_id}, 32'd0);
            check("bp_readys", {30'd0, r1_ready, r0_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        push_exp(1'b1, 8'h22, 1'b0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy", {31'd0, busy}, 32'd0);
        check("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_r1_ready", {31'd0, r1_ready}, 32'd1);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;

        // Reset while in EXEC discards the op
        r0_a = 8'h55; r0_b = 8'h0A; r0_sel = 3'b011; r0_cin = 1'b0; r0_valid = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0_ready) begin got = 1'b1; break; end
            end
            check("rx_accept", {31'd0, got}, 32'd1);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rx_busy", {31'd0, busy}, 32'd0);
        check("rx_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (resp_valid) seen = 1'b1;
            end
            check("rx_no_resp", {31'd0, seen}, 32'd0);
        end
        @(posedge clk); #1;
        do_op(1'b0, 8'h12, 8'h34, 3'b011, 1'b1, 8'h47, 1'b0, 1'b1);

        check("final_queue", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
